// File: rtl/svm_pkg.sv
// rtl/svm_pkg.sv - shared types and arithmetic helpers for the SVM decision stage
//
// Contents:
//   state_e     - decision FSM states
//   fea_width   - feature/score width from integer and fraction bits
//   acc_width   - accumulator width that cannot overflow over one window
//   idx_width   - index width for a count of items (at least 1 bit)
//   sat_narrow  - clamp a wide signed value into a w-bit signed range
//   beats       - argmax step: a candidate displaces the best only if strictly greater
package svm_pkg;

   typedef enum logic [1:0] {
      ST_ACC = 2'd0,
      ST_FIN = 2'd1,
      ST_SEL = 2'd2,
      ST_OUT = 2'd3
   } state_e;

   function automatic int fea_width(input int fea_i, input int fea_f);
      return fea_i + fea_f;
   endfunction

   // One extra bit beyond log2 growth keeps the sign when every beat is at full scale.
   function automatic int acc_width(input int fea_w, input int n_part);
      return fea_w + $clog2(n_part) + 1;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) begin
         return hi;
      end
      if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

   // Strict compare: on a tie the earlier (lower-index) class keeps its place.
   function automatic logic beats(input logic signed [63:0] cand, input logic signed [63:0] best);
      return cand > best;
   endfunction

endpackage

// File: rtl/svm_score_acc_led.sv
// rtl/svm_score_acc_led.sv - retriggerable LED pulse stretcher
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   trig - one-cycle trigger; (re)loads the hold counter
//   led  - high for LED_HOLD cycles after the most recent trigger
module led_stretch #(
   parameter int LED_HOLD = 25000000
) (
   input  logic clk,
   input  logic rst,
   input  logic trig,
   output logic led
);

   localparam int CNT_W = $clog2(LED_HOLD + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             led_q;

   always_comb begin
      cnt_d = cnt_q;
      if (trig) begin
         cnt_d = CNT_W'(LED_HOLD);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         led_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         led_q <= (cnt_d != '0);
      end
   end

   assign led = led_q;

endmodule

// File: rtl/svm_score_acc.sv
// rtl/svm_score_acc.sv - multi-class SVM score accumulator, argmax and result handshake
//
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   sof                         - start of frame; drops the partial window, sw_id <- 0
//   i_valid/i_ready/i_psum      - partial-sum beats, class c at [c*FEA_W +: FEA_W]
//   b_load/b_sel/bias           - bias register write
//   t_load                      - threshold write (value on bias)
//   o_valid/o_ready             - result handshake
//   result/cls_id/is_person     - best saturated score, its class, above-threshold flag
//   sw_id                       - window ID of the current result
//   frame_done                  - pulse after the last window of a frame is taken
//   led                         - stretched detection indicator
module svm_score_acc
   import svm_pkg::*;
#(
   parameter int FEA_I    = 4,
   parameter int FEA_F    = 16,
   parameter int N_CLS    = 2,
   parameter int N_PART   = 36,
   parameter int SW_W     = 11,
   parameter int N_SW     = 1200,
   parameter int LED_HOLD = 25000000,
   localparam int FEA_W   = fea_width(FEA_I, FEA_F),
   localparam int CLS_W   = idx_width(N_CLS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sof,
   input  logic                   i_valid,
   output logic                   i_ready,
   input  logic [N_CLS*FEA_W-1:0] i_psum,
   input  logic                   b_load,
   input  logic [CLS_W-1:0]       b_sel,
   input  logic [FEA_W-1:0]       bias,
   input  logic                   t_load,
   output logic                   o_valid,
   input  logic                   o_ready,
   output logic [FEA_W-1:0]       result,
   output logic [CLS_W-1:0]       cls_id,
   output logic                   is_person,
   output logic [SW_W-1:0]        sw_id,
   output logic                   frame_done,
   output logic                   led
);

   localparam int ACC_W = acc_width(FEA_W, N_PART);
   localparam int PC_W  = idx_width(N_PART);

   state_e                  state_q;
   logic [PC_W-1:0]         part_cnt_q;
   logic signed [ACC_W-1:0] acc_q   [N_CLS];
   logic signed [FEA_W-1:0] score_q [N_CLS];
   logic signed [FEA_W-1:0] bias_q  [N_CLS];
   logic signed [FEA_W-1:0] thr_q;
   logic                    i_ready_q;
   logic                    o_valid_q;
   logic [FEA_W-1:0]        result_q;
   logic [CLS_W-1:0]        cls_q;
   logic                    is_person_q;
   logic [SW_W-1:0]         sw_q;
   logic                    frame_done_q;

   logic signed [FEA_W-1:0] score_d [N_CLS];
   logic signed [FEA_W-1:0] best_score;
   logic [CLS_W-1:0]        best_cls;
   logic [31:0]             b_sel_ext;
   logic                    take;
   logic                    last_beat;

   assign b_sel_ext = 32'(b_sel);
   assign take      = o_valid_q && o_ready;
   assign last_beat = (part_cnt_q == PC_W'(N_PART - 1));

   // Bias is added at full precision before clamping so a large bias can
   // pull an out-of-range sum back into range.
   always_comb begin
      for (int c = 0; c < N_CLS; c++) begin
         score_d[c] = FEA_W'(sat_narrow(64'(acc_q[c]) + 64'(bias_q[c]), FEA_W));
      end
   end

   always_comb begin
      best_score = score_q[0];
      best_cls   = '0;
      for (int c = 1; c < N_CLS; c++) begin
         if (beats(64'(score_q[c]), 64'(best_score))) begin
            best_score = score_q[c];
            best_cls   = CLS_W'(c);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_ACC;
         part_cnt_q   <= '0;
         i_ready_q    <= 1'b1;
         o_valid_q    <= 1'b0;
         result_q     <= '0;
         cls_q        <= '0;
         is_person_q  <= 1'b0;
         sw_q         <= '0;
         frame_done_q <= 1'b0;
         thr_q        <= '0;
         for (int c = 0; c < N_CLS; c++) begin
            acc_q[c]   <= '0;
            score_q[c] <= '0;
            bias_q[c]  <= '0;
         end
      end else begin
         frame_done_q <= 1'b0;

         // Parameter registers load in every state, including during sof.
         for (int c = 0; c < N_CLS; c++) begin
            if (b_load && (b_sel_ext == 32'(c))) begin
               bias_q[c] <= bias;
            end
         end
         if (t_load) begin
            thr_q <= bias;
         end

         if (sof) begin
            state_q    <= ST_ACC;
            part_cnt_q <= '0;
            i_ready_q  <= 1'b1;
            o_valid_q  <= 1'b0;
            sw_q       <= '0;
            for (int c = 0; c < N_CLS; c++) begin
               acc_q[c] <= '0;
            end
         end else begin
            unique case (state_q)
               ST_ACC: begin
                  if (i_valid) begin
                     for (int c = 0; c < N_CLS; c++) begin
                        acc_q[c] <= acc_q[c] + ACC_W'($signed(i_psum[c*FEA_W +: FEA_W]));
                     end
                     if (last_beat) begin
                        part_cnt_q <= '0;
                        i_ready_q  <= 1'b0;
                        state_q    <= ST_FIN;
                     end else begin
                        part_cnt_q <= part_cnt_q + PC_W'(1);
                     end
                  end
               end
               ST_FIN: begin
                  for (int c = 0; c < N_CLS; c++) begin
                     score_q[c] <= score_d[c];
                  end
                  state_q <= ST_SEL;
               end
               ST_SEL: begin
                  result_q    <= best_score;
                  cls_q       <= best_cls;
                  is_person_q <= (best_score > thr_q);
                  o_valid_q   <= 1'b1;
                  state_q     <= ST_OUT;
               end
               ST_OUT: begin
                  if (take) begin
                     o_valid_q    <= 1'b0;
                     i_ready_q    <= 1'b1;
                     frame_done_q <= (sw_q == SW_W'(N_SW - 1));
                     sw_q         <= (sw_q == SW_W'(N_SW - 1)) ? '0 : sw_q + SW_W'(1);
                     for (int c = 0; c < N_CLS; c++) begin
                        acc_q[c] <= '0;
                     end
                     state_q <= ST_ACC;
                  end
               end
               default: state_q <= ST_ACC;
            endcase
         end
      end
   end

   led_stretch #(
      .LED_HOLD (LED_HOLD)
   ) u_led (
      .clk  (clk),
      .rst  (rst),
      .trig (take && is_person_q && !sof),
      .led  (led)
   );

   assign i_ready    = i_ready_q;
   assign o_valid    = o_valid_q;
   assign result     = result_q;
   assign cls_id     = cls_q;
   assign is_person  = is_person_q;
   assign sw_id      = sw_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_svm_score_acc.sv
// tb/tb_svm_score_acc.sv - self-checking bench for svm_score_acc
module tb_svm_score_acc;

   localparam int FEA_I    = 4;
   localparam int FEA_F    = 16;
   localparam int FEA_W    = 20;
   localparam int N_CLS    = 2;
   localparam int N_PART   = 4;
   localparam int SW_W     = 4;
   localparam int N_SW     = 3;
   localparam int LED_HOLD = 8;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   sof;
   logic                   i_valid;
   logic                   i_ready;
   logic [N_CLS*FEA_W-1:0] i_psum;
   logic                   b_load;
   logic [0:0]             b_sel;
   logic [FEA_W-1:0]       bias;
   logic                   t_load;
   logic                   o_valid;
   logic                   o_ready;
   logic [FEA_W-1:0]       result;
   logic [0:0]             cls_id;
   logic                   is_person;
   logic [SW_W-1:0]        sw_id;
   logic                   frame_done;
   logic                   led;

   always #5 clk = ~clk;

   svm_score_acc #(
      .FEA_I(FEA_I), .FEA_F(FEA_F), .N_CLS(N_CLS), .N_PART(N_PART),
      .SW_W(SW_W), .N_SW(N_SW), .LED_HOLD(LED_HOLD)
   ) dut (
      .clk(clk), .rst(rst), .sof(sof), .i_valid(i_valid), .i_ready(i_ready),
      .i_psum(i_psum), .b_load(b_load), .b_sel(b_sel), .bias(bias), .t_load(t_load),
      .o_valid(o_valid), .o_ready(o_ready), .result(result), .cls_id(cls_id),
      .is_person(is_person), .sw_id(sw_id), .frame_done(frame_done), .led(led)
   );

   typedef struct {
      int p0; int p1; int b0; int b1; int thr;
      int res; int cls; int pers; int hold;
   } vec_t;

   vec_t vecs[6];
   int   n_cmp = 0;
   int   n_err = 0;
   int   mb[N_CLS];
   int   mthr;
   int   exp_sw;
   int   beat0[N_PART];
   int   beat1[N_PART];
   int   ncyc = 0;
   int   last_pos = -1000;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // LED reference: high on the 1st..LED_HOLD-th cycle after the latest positive take.
   always @(negedge clk) begin
      int d;
      d = ncyc - last_pos;
      chk("led", int'(led), (d >= 1 && d <= LED_HOLD) ? 1 : 0);
      if (rst) begin
         last_pos = -1000;
      end else if (o_valid && o_ready && is_person && !sof) begin
         last_pos = ncyc;
      end
      ncyc++;
   end

   function automatic int sx(input int v);
      int m;
      m = v & 'hFFFFF;
      return (m >= 'h80000) ? m - 'h100000 : m;
   endfunction

   function automatic int sat20(input longint v);
      if (v > 524287) return 524287;
      if (v < -524288) return -524288;
      return int'(v);
   endfunction

   task automatic model(output int res, output int cls, output int pers);
      longint s;
      int     sc[N_CLS];
      for (int c = 0; c < N_CLS; c++) begin
         s = mb[c];
         for (int k = 0; k < N_PART; k++) begin
            s += (c == 0) ? beat0[k] : beat1[k];
         end
         sc[c] = sat20(s);
      end
      cls = 0;
      for (int c = 1; c < N_CLS; c++) begin
         if (sc[c] > sc[cls]) cls = c;
      end
      res  = sc[cls] & 'hFFFFF;
      pers = (sc[cls] > mthr) ? 1 : 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_bias(input int sel, input int val);
      b_load = 1'b1;
      b_sel  = sel[0:0];
      bias   = val[19:0];
      tick();
      b_load = 1'b0;
      mb[sel] = val;
   endtask

   task automatic load_thr(input int val);
      t_load = 1'b1;
      bias   = val[19:0];
      tick();
      t_load = 1'b0;
      mthr = val;
   endtask

   task automatic fill(input int p0, input int p1);
      for (int k = 0; k < N_PART; k++) begin
         beat0[k] = p0;
         beat1[k] = p1;
      end
   endtask

   task automatic send_beats(input int n);
      logic [19:0] a;
      logic [19:0] b;
      int          g;
      for (int k = 0; k < n; k++) begin
         a = beat0[k][19:0];
         b = beat1[k][19:0];
         i_valid = 1'b1;
         i_psum  = {b, a};
         g = 0;
         while (!i_ready && g < 50) begin
            tick();
            g++;
         end
         tick();
      end
      i_valid = 1'b0;
   endtask

   // Sends one window and waits for o_valid; optionally loads bias0 in the FIN cycle.
   task automatic run_window(input bit fin_ld, input int fin_val);
      int lat;
      send_beats(N_PART);
      if (fin_ld) begin
         b_load = 1'b1;
         b_sel  = 1'b0;
         bias   = fin_val[19:0];
      end
      lat = 0;
      while (!o_valid && lat < 20) begin
         tick();
         lat++;
         if (fin_ld && lat == 1) begin
            b_load = 1'b0;
            mb[0]  = fin_val;
         end
      end
      chk("o_valid_latency", lat, 2);
   endtask

   task automatic check_result(input int er, input int ec, input int ep);
      chk("result", int'(result), er);
      chk("cls_id", int'(cls_id), ec);
      chk("is_person", int'(is_person), ep);
      chk("sw_id", int'(sw_id), exp_sw);
   endtask

   task automatic take(input int hold, input int er, input int ec, input int ep);
      int want;
      want = er | (ec << 20) | (ep << 21) | (1 << 23);
      o_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         i_valid = 1'b1;
         i_psum  = 40'h12345_6789A;
         tick();
         chk("hold_stable", int'({o_valid, i_ready, is_person, cls_id, result}), want);
      end
      o_ready = 1'b1;
      tick();
      o_ready = 1'b0;
      i_valid = 1'b0;
      chk("take_o_valid", int'(o_valid), 0);
      chk("take_i_ready", int'(i_ready), 1);
      chk("frame_done", int'(frame_done), (exp_sw == N_SW - 1) ? 1 : 0);
      exp_sw = (exp_sw + 1) % N_SW;
      chk("sw_id_next", int'(sw_id), exp_sw);
      tick();
      chk("frame_done_end", int'(frame_done), 0);
   endtask

   task automatic check_reset();
      chk("rst_i_ready", int'(i_ready), 1);
      chk("rst_o_valid", int'(o_valid), 0);
      chk("rst_result", int'(result), 0);
      chk("rst_cls_id", int'(cls_id), 0);
      chk("rst_is_person", int'(is_person), 0);
      chk("rst_sw_id", int'(sw_id), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      mb[0] = 0; mb[1] = 0; mthr = 0; exp_sw = 0;
   endtask

   task automatic model_window(input int hold);
      int er, ec, ep;
      model(er, ec, ep);
      run_window(1'b0, 0);
      check_result(er, ec, ep);
      take(hold, er, ec, ep);
   endtask

   initial begin
      int er, ec, ep;
      rst = 1'b1; sof = 1'b0; i_valid = 1'b0; i_psum = '0; b_load = 1'b0;
      b_sel = 1'b0; bias = '0; t_load = 1'b0; o_ready = 1'b0;
      vecs[0] = '{'h04000, 0, -32768, 0, 'h04000, 'h08000, 0, 1, 10};
      vecs[1] = '{524287, 0, 0, 0, 0, 'h7FFFF, 0, 1, 0};
      vecs[2] = '{-524288, -524288, 0, 0, 0, 'h80000, 0, 0, 2};
      vecs[3] = '{-256, 256, 0, 256, 'h500, 'h00500, 1, 0, 1};
      vecs[4] = '{'h20000, 524287, -1, 0, 524286, 'h7FFFF, 0, 1, 0};
      vecs[5] = '{'h100, 'h100, 0, 1, -5, 'h00401, 1, 1, 3};
      repeat (3) tick();
      rst = 1'b0;
      check_reset();

      for (int v = 0; v < 6; v++) begin
         load_bias(0, vecs[v].b0);
         load_bias(1, vecs[v].b1);
         load_thr(vecs[v].thr);
         fill(vecs[v].p0, vecs[v].p1);
         run_window(1'b0, 0);
         check_result(vecs[v].res, vecs[v].cls, vecs[v].pers);
         take(vecs[v].hold, vecs[v].res, vecs[v].cls, vecs[v].pers);
      end

      // Tie at threshold; a bias write during FIN must not touch this window.
      load_bias(0, 0);
      load_bias(1, 0);
      load_thr('h1000);
      fill('h400, 'h400);
      run_window(1'b1, 'h10000);
      check_result('h1000, 0, 0);
      take(0, 'h1000, 0, 0);
      fill(0, 0);
      model_window(0);

      // sof mid-window: the two early beats are dropped and sw_id restarts.
      fill('h30000, 'h30000);
      send_beats(2);
      sof = 1'b1; i_valid = 1'b1; i_psum = {20'h30000, 20'h30000};
      tick();
      sof = 1'b0; i_valid = 1'b0;
      exp_sw = 0;
      chk("sof_sw_id", int'(sw_id), 0);
      chk("sof_i_ready", int'(i_ready), 1);
      fill('h1000, -'h800);
      model_window(0);

      // Back-to-back positive windows retrigger the LED.
      load_thr(0);
      fill('h100, 0);
      model_window(0);
      model_window(0);
      fill(-'h100, -'h200);
      model_window(0);
      repeat (12) tick();

      for (int r = 0; r < 24; r++) begin
         if ($urandom_range(0, 2) == 0) begin
            load_bias(0, sx(int'($urandom_range(0, 'hFFFFF))));
            load_bias(1, int'($urandom_range(0, 'hFFFF)) - 'h8000);
         end
         if ($urandom_range(0, 2) == 0) begin
            load_thr(int'($urandom_range(0, 'h3FFFF)) - 'h20000);
         end
         for (int k = 0; k < N_PART; k++) begin
            if ($urandom_range(0, 1) == 1) begin
               beat0[k] = sx(int'($urandom_range(0, 'hFFFFF)));
               beat1[k] = sx(int'($urandom_range(0, 'hFFFFF)));
            end else begin
               beat0[k] = int'($urandom_range(0, 'hFFFF)) - 'h8000;
               beat1[k] = int'($urandom_range(0, 'hFFFF)) - 'h8000;
            end
         end
         model_window(int'($urandom_range(0, 3)));
      end

      // Reset mid-window, then mid-OUT.
      fill('h7000, 'h7000);
      send_beats(2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset();
      fill('h200, 'h300);
      model_window(0);
      fill('h1000, 0);
      run_window(1'b0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset();
      fill(-'h40, 'h40);
      model_window(1);
      repeat (10) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/svm_score_acc.md
# svm_score_acc

- Multi-class SVM decision stage of the HOG→SVM pipeline.
- Accumulates N_PART signed partial dot-products per slide window for N_CLS classes, then adds per-class runtime-loaded biases and saturates.
- Selects the best class, compares it with a programmable threshold, and emits one handshaken result per window with a wrapping window ID.
- Also drives a retriggerable LED stretcher; generalises the single-bias, single-class person detector.

## Interface
Parameters:
- FEA_I, 4, integer bits of feature/score (signed Q format)
- FEA_F, 16, fraction bits; FEA_W = FEA_I+FEA_F
- N_CLS, 2, number of classes
- N_PART, 36, partial sums per window
- SW_W, 11, window-ID width
- N_SW, 1200, windows per frame (≤ 2^SW_W)
- LED_HOLD, 25000000, LED on-time in cycles (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  sync active-high reset
- sof  in  1  start of frame: discard partial window, sw_id←0
- i_valid  in  1  partial-sum beat valid
- i_ready  out  1  beat accepted when i_valid&i_ready
- i_psum  in  N_CLS*FEA_W  signed partial sums, class c at [c*FEA_W +: FEA_W]
- b_load  in  1  write bias[b_sel]←bias
- b_sel  in  $clog2(N_CLS) (min 1)  bias index
- bias  in  FEA_W  signed bias value
- t_load  in  1  thr←bias
- o_valid  out  1  result valid, held until o_ready
- o_ready  in  1  result consumer ready
- result  out  FEA_W  saturated best score
- cls_id  out  $clog2(N_CLS) (min 1)  best class
- is_person  out  1  result > thr (signed, strict)
- sw_id  out  SW_W  window ID of current result
- frame_done  out  1  one-cycle pulse after last window of frame is taken
- led  out  1  stretched detection indicator

## Operation
- FSM states: ACC → FIN → SEL → OUT → ACC. Reset enters ACC.
- ACC: i_ready=1. Each accepted beat adds sign-extended i_psum per class into ACC_W = FEA_W+$clog2(N_PART)+1 accumulators. part_cnt counts 0..N_PART-1; the last beat moves the FSM to FIN.
- FIN: score[c] = sat(acc[c] + bias[c]), saturated to [-2^(FEA_W-1), 2^(FEA_W-1)-1].
- SEL: argmax over scores with ties going to the lowest index. Registers result, cls_id and is_person; sets o_valid; goes to OUT.
- OUT: i_ready=0; outputs stable. On o_valid&o_ready:
  - clear o_valid and accumulators;
  - sw_id wraps N_SW-1→0, otherwise increments;
  - frame_done pulses next cycle if the taken window was N_SW-1;
  - return to ACC.
- Bias/threshold registers:
  - b_load/t_load are accepted in any state.
  - FIN uses the pre-edge register values, so a load coincident with FIN affects the next window.
  - b_sel ≥ N_CLS is ignored.
- sof:
  - Highest priority; a beat coincident with sof is discarded.
  - Clears accumulators and part_cnt, sets sw_id←0 and o_valid←0, goes to ACC.
  - No frame_done.
- led:
  - Any taken result with is_person=1 loads the hold counter with LED_HOLD; led=1 while the counter is non-zero.
  - Retriggering reloads the counter.
  - sof does not affect led.
- Reset values: i_ready 1, o_valid 0, result 0, cls_id 0, is_person 0, sw_id 0, frame_done 0, led 0. All biases and thr are 0, accumulators 0.

## Timing
- Last beat accepted at edge T; o_valid high after edge T+2, i.e. visible 3 cycles after the last beat's cycle.
- Handshake at edge H: i_ready high after H; frame_done high for the single cycle after H.
- Minimum window period N_PART+3 cycles with o_ready tied high.
- led rises the cycle after the positive handshake and stays high exactly LED_HOLD cycles.
- rst mid-window or mid-OUT: everything returns to reset values next cycle; the partial window is lost.

## Structure
- Package svm_pkg:
  - state enum;
  - FEA_W/ACC_W localparam helpers;
  - saturating narrow function;
  - signed tie-break compare function.
- Sub-module led_stretch (counter + led register, parameter LED_HOLD, inputs trig).
- The argmax is N_CLS-wide combinational within SEL.

## Test plan
Common config: N_CLS=2, N_PART=4, FEA_W=20, Q4.16.
1. **Basic positive.** bias0=0xF8000 (−0.5), bias1=0, thr=0x04000; class0 beats 4×0x04000, class1 zeros → result 0x08000, cls_id 0, is_person 1, o_valid 3 cycles after last beat, led rises.
2. **Saturation.** 4×0x7FFFF (class0) → result 0x7FFFF. 4×0x80000 on both classes → result 0x80000, cls_id 0.
3. **Tie and threshold.** Both scores 0x01000, thr=0x01000 → cls_id 0, is_person 0. b_load coincident with FIN does not change this result.
4. **Backpressure.** o_ready low 10 cycles → outputs stable, i_ready 0, i_valid beats not accepted. Then handshake → sw_id 0→1, i_ready high next cycle.
5. **Wrap and sof.** With N_SW=3, three windows → sw_id 0,1,2 then 0, one frame_done pulse. sof after 2 beats → next 4 beats form window with sw_id 0 and the earlier beats are discarded.
6. **LED stretch.** LED_HOLD=8: positive at t → led high for cycles t+1..t+8. Second positive at t+5 → led held through t+13.
